// File: rtl/gpio_ctrl_if.sv
// Data-memory bus bundle shared by the core (master) and memory-mapped peripherals (slave).
// Address, strobes and write data come from the core; read data and window hit return from the peripheral.
interface gpio_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WIDTH  = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_hit;

  modport master (
    output mem_addr, mem_write_en, mem_read_en, mem_wdata,
    input  mem_rdata, mem_hit
  );

  modport slave (
    input  mem_addr, mem_write_en, mem_read_en, mem_wdata,
    output mem_rdata, mem_hit
  );
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output/direction registers, synchronised inputs and
// edge-triggered sticky interrupt pending bits in an 8-entry bus window.
module gpio_ctrl #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'hF0,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  gpio_ctrl_if.slave        bus,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_DIR  = 3'd1;
  localparam logic [2:0] OFF_IN   = 3'd2;
  localparam logic [2:0] OFF_RISE = 3'd3;
  localparam logic [2:0] OFF_FALL = 3'd4;
  localparam logic [2:0] OFF_PEND = 3'd5;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             hit_s;
  logic [2:0]       off_s;
  logic             wr_s;
  logic             rd_s;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] in_val_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] rd_val_s;

  // BASE_ADDR is 8-aligned, so the window is a match on the upper address bits.
  assign hit_s    = (bus.mem_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
  assign off_s    = bus.mem_addr[2:0];
  assign wr_s     = bus.mem_write_en & hit_s;
  assign rd_s     = bus.mem_read_en & hit_s;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign in_val_s = (dir_q & out_q) | (~dir_q & sync_s);
  assign rise_s   = sync_s & ~sync_d_q & ~dir_q & rise_en_q;
  assign fall_s   = ~sync_s & sync_d_q & ~dir_q & fall_en_q;

  assign bus.mem_hit   = hit_s;
  assign bus.mem_rdata = rdata_q;
  assign gpio_out      = out_q;
  assign gpio_oe       = dir_q;
  assign irq           = |pend_q;

  // Input synchroniser chain plus the one-cycle-delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      sync_d_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_d_q <= sync_s;
    end
  end

  // Register writes; W1C and a same-cycle edge event resolve with set winning.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_s     = '0;
    if (wr_s) begin
      case (off_s)
        OFF_OUT:  out_d     = bus.mem_wdata;
        OFF_DIR:  dir_d     = bus.mem_wdata;
        OFF_RISE: rise_en_d = bus.mem_wdata;
        OFF_FALL: fall_en_d = bus.mem_wdata;
        OFF_PEND: w1c_s     = bus.mem_wdata;
        default:  w1c_s     = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    pend_d = (pend_q & ~w1c_s) | rise_s | fall_s;
  end

  // Read mux sees pre-write register values, so a simultaneous read returns the old contents.
  always_comb begin
    case (off_s)
      OFF_OUT:  rd_val_s = out_q;
      OFF_DIR:  rd_val_s = dir_q;
      OFF_IN:   rd_val_s = in_val_s;
      OFF_RISE: rd_val_s = rise_en_q;
      OFF_FALL: rd_val_s = fall_en_q;
      OFF_PEND: rd_val_s = pend_q;
      default:  rd_val_s = '0;
    endcase
    if (rd_s) begin
      rdata_d = rd_val_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Architectural register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: read expectations queue up when a read is issued
// and are checked when the registered read data appears.
module tb_gpio_ctrl;
  localparam int W  = 8;
  localparam int AW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  gpio_ctrl_if #(.ADDR_W(AW), .WIDTH(W)) bus ();

  gpio_ctrl #(
    .WIDTH(W), .ADDR_W(AW), .BASE_ADDR(8'hF0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pop_read();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, bus.mem_rdata, e.exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [W-1:0] data);
    bus.mem_addr     = addr;
    bus.mem_wdata    = data;
    bus.mem_write_en = 1'b1;
    tick();
    bus.mem_write_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [W-1:0] exp, input string tag);
    sb_t e;
    bus.mem_addr    = addr;
    bus.mem_read_en = 1'b1;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    tick();
    bus.mem_read_en = 1'b0;
    pop_read();
  endtask

  initial begin
    rst              = 1'b1;
    gpio_in          = '0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_write_en = 1'b0;
    bus.mem_read_en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_gpio_oe", gpio_oe, 8'h00);
    check_bit("rst_irq", irq, 1'b0);
    check("rst_rdata", bus.mem_rdata, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd(8'hF0 + 8'(i), 8'h00, $sformatf("rst_read_off%0d", i));
    end

    // Output and direction registers, IN mixes driven and sampled pins.
    wr(8'hF0, 8'hA5);
    wr(8'hF1, 8'h0F);
    gpio_in = 8'h30;
    tick();
    tick();
    tick();
    check("gpio_out_a5", gpio_out, 8'hA5);
    check("gpio_oe_0f", gpio_oe, 8'h0F);
    rd(8'hF2, 8'h35, "in_mixed");
    rd(8'hF1, 8'h0F, "dir_readback");

    // Rising edge on pin 0 sets IRQ_PEND three edges after the pin changes.
    wr(8'hF1, 8'h00);
    wr(8'hF3, 8'h01);
    gpio_in = 8'h31;
    tick();
    tick();
    check_bit("rise_irq_before", irq, 1'b0);
    tick();
    check_bit("rise_irq_edge3", irq, 1'b1);
    rd(8'hF5, 8'h01, "rise_pend");
    wr(8'hF5, 8'h01);
    check_bit("w1c_irq_low", irq, 1'b0);
    rd(8'hF5, 8'h00, "w1c_pend");

    // Falling edge on pin 7 coinciding with a W1C of the same bit: set wins.
    wr(8'hF4, 8'h80);
    gpio_in = 8'hB1;
    tick();
    tick();
    tick();
    tick();
    check_bit("fall_setup_irq", irq, 1'b0);
    gpio_in = 8'h31;
    tick();
    tick();
    wr(8'hF5, 8'h80);
    check_bit("fall_vs_w1c_irq", irq, 1'b1);
    rd(8'hF5, 8'h80, "fall_vs_w1c_pend");
    wr(8'hF4, 8'h00);
    rd(8'hF5, 8'h80, "disable_keeps_pend");
    wr(8'hF5, 8'h80);
    rd(8'hF5, 8'h00, "fall_cleared");

    // Window boundaries and reserved offsets.
    bus.mem_addr = 8'hEF;
    #1;
    check_bit("hit_ef", bus.mem_hit, 1'b0);
    bus.mem_addr = 8'hF8;
    #1;
    check_bit("hit_f8", bus.mem_hit, 1'b0);
    bus.mem_addr = 8'hF7;
    #1;
    check_bit("hit_f7", bus.mem_hit, 1'b1);
    wr(8'hEF, 8'hFF);
    wr(8'hF8, 8'hFF);
    rd(8'hF8, 8'h00, "outside_read_holds");
    check("outside_gpio_out", gpio_out, 8'hA5);
    rd(8'hF0, 8'hA5, "out_unchanged");
    rd(8'hEF, 8'hA5, "outside_read_holds2");
    wr(8'hF6, 8'hFF);
    rd(8'hF6, 8'h00, "reserved6");
    rd(8'hF7, 8'h00, "reserved7");

    // Simultaneous read and write returns the pre-write value.
    bus.mem_addr     = 8'hF0;
    bus.mem_wdata    = 8'h3C;
    bus.mem_write_en = 1'b1;
    bus.mem_read_en  = 1'b1;
    sb_q.push_back('{tag: "rw_same_cycle", exp: 8'hA5});
    tick();
    bus.mem_write_en = 1'b0;
    bus.mem_read_en  = 1'b0;
    pop_read();
    check("rw_gpio_out", gpio_out, 8'h3C);

    // Reset during operation clears read data and outputs.
    wr(8'hF0, 8'hA5);
    wr(8'hF1, 8'hFF);
    rd(8'hF0, 8'hA5, "pre_reset_read");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_rdata", bus.mem_rdata, 8'h00);
    check("reset_gpio_out", gpio_out, 8'h00);
    check("reset_gpio_oe", gpio_oe, 8'h00);
    check_bit("reset_irq", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised, memory-mapped GPIO controller that replaces the fixed 8-bit `in_gpio`/`out_gpio` pins of `uC_8bits` with a register block on the data-memory bus. It provides:
- per-pin direction control;
- input synchronisation;
- rising/falling edge detection with sticky, write-1-to-clear interrupt pending bits;
- a level interrupt output to the core.

It sits beside the EEPROM on the same address/write-enable bus and claims an 8-entry window.

## Interface
- `WIDTH`, 8: pin count and register data width (1..32).
- `ADDR_W`, 8: bus address width.
- `BASE_ADDR`, 8'hF0: window base; must be a multiple of 8.
- `SYNC_STAGES`, 2: input synchroniser depth (>=2).

Ports (clock and reset first):
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  in  ADDR_W  bus address.
- `mem_write_en`  in  1  write strobe, single cycle.
- `mem_read_en`  in  1  read strobe, single cycle.
- `mem_wdata`  in  WIDTH  write data.
- `mem_rdata`  out  WIDTH  registered read data.
- `mem_hit`  out  1  combinational: `mem_addr` inside `[BASE_ADDR, BASE_ADDR+7]`.
- `gpio_in`  in  WIDTH  asynchronous pad inputs.
- `gpio_out`  out  WIDTH  pad output values (= OUT register).
- `gpio_oe`  out  WIDTH  pad output enables (= DIR register, 1 = output).
- `irq`  out  1  OR of all IRQ_PEND bits.

## Operation
Register map (offset = `mem_addr - BASE_ADDR`):
- 0 OUT: read/write.
- 1 DIR: read/write.
- 2 IN: read-only. Bit i = DIR[i] ? OUT[i] : sync[i].
- 3 RISE_EN: read/write.
- 4 FALL_EN: read/write.
- 5 IRQ_PEND: read returns value; write is W1C.
- 6, 7: reserved. Read 0; writes ignored.

Input path and edge detection:
- `gpio_in` passes through SYNC_STAGES flops to give `sync`. A further flop holds `sync_d`.
- rise[i] = sync[i] & ~sync_d[i] & ~DIR[i] & RISE_EN[i].
- fall[i] = ~sync[i] & sync_d[i] & ~DIR[i] & FALL_EN[i].
- IRQ_PEND[i] sets on rise[i] | fall[i] and stays set until cleared by a W1C write.

Bus access:
- Writes and reads outside the window are ignored. `mem_rdata` holds its previous value.
- `mem_write_en` and `mem_read_en` asserted together: the write commits and the read returns the pre-write value.
- Writes to offset 2 (IN) are ignored.

Reset values (all registers, sync flops, `sync_d`): 0. Therefore:
- `gpio_out` = 0, `gpio_oe` = 0, `mem_rdata` = 0, `irq` = 0.
- No edge is detected in the first cycles after reset, because all RISE_EN/FALL_EN bits are 0.

## Timing
- Writes take effect at the edge where `mem_write_en` is sampled high. `gpio_out`/`gpio_oe` change on that same edge.
- Read latency is 1 cycle: `mem_rdata` is valid in the cycle after `mem_read_en`.
- Pin to IN latency: a `gpio_in` change is visible in IN after SYNC_STAGES edges.
- Pin to IRQ_PEND latency: SYNC_STAGES+1 edges. `irq` follows combinationally from IRQ_PEND, so there is no extra cycle.
- W1C clear and a new edge on the same bit in the same cycle: set wins, and the bit stays 1.
- Clearing a bit whose edge is not recurring: the bit reads 0 on the next read. `irq` drops on the edge after the write if no other bit is pending.
- Disabling RISE_EN/FALL_EN does not clear existing pending bits.
- Changing DIR from 1 to 0 while the pin differs from `sync_d` can produce one edge event. This is intended and documented; software clears IRQ_PEND after a DIR change.
- Pulses on `gpio_in` shorter than one clock may be missed. There is no debounce.
- `rst` asserted mid-operation returns all state to reset values at the next edge. An in-flight read returns 0.

## Test plan
- Reset, then read offsets 0–7 -> all return 0; `irq` = 0; `gpio_oe` = 0.
- Write OUT = 8'hA5, DIR = 8'h0F, read IN with `gpio_in` = 8'h30 held for 3+ cycles -> `gpio_out` = 8'hA5, `gpio_oe` = 8'h0F, IN = 8'h35.
- RISE_EN = 8'h01, toggle `gpio_in[0]` 0->1 -> IRQ_PEND = 8'h01 exactly 3 edges after the pin change (SYNC_STAGES = 2); `irq` = 1. Write 8'h01 to offset 5 -> IRQ_PEND = 0, `irq` = 0.
- FALL_EN = 8'h80, hold a falling edge on pin 7 in the same cycle a W1C of 8'h80 lands -> IRQ_PEND[7] stays 1.
- Access at addr 8'hEF and 8'hF8 (outside the window), then offset 6 -> `mem_hit` = 0 outside the window, registers unchanged, offset 6 reads 0.
- Assert `rst` one cycle after a read of OUT = 8'hA5 is issued -> `mem_rdata` = 0 and all outputs 0 on the following edge.
